bp_update_queue: RTL and testbench

BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

---
 rtl/bp_update_queue_if.sv | 45 ++++
 rtl/bp_update_queue.sv | 123 ++++++++++++
 tb/tb_bp_update_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Handshake bundle between the execute-stage resolver, the update queue and the branch predictor.
// slave = queue side, master = producer/consumer side.
interface bp_update_queue_if #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                  enq_valid_i;
   logic                  enq_ready_o;
   logic [ADDR_WIDTH-1:0] enq_pc_i;
   logic                  enq_taken_i;
   logic [ADDR_WIDTH-1:0] enq_target_i;
   logic                  enq_is_branch_i;
   logic                  enq_is_jal_i;
   logic                  enq_is_jalr_i;
   logic [ADDR_WIDTH-1:0] enq_link_i;
   logic                  flush_i;
   logic                  bp_ready_i;
   logic                  update_o;
   logic [ADDR_WIDTH-1:0] update_pc_o;
   logic [ADDR_WIDTH-1:0] actual_target_o;
   logic [ADDR_WIDTH-1:0] jal_target_o;
   logic                  actual_taken_o;
   logic                  is_branch_o;
   logic                  is_jal_o;
   logic                  is_jalr_o;
   logic [CNT_W-1:0]      count_o;

   modport slave (
      input  enq_valid_i, enq_pc_i, enq_taken_i, enq_target_i,
             enq_is_branch_i, enq_is_jal_i, enq_is_jalr_i, enq_link_i,
             flush_i, bp_ready_i,
      output enq_ready_o, update_o, update_pc_o, actual_target_o, jal_target_o,
             actual_taken_o, is_branch_o, is_jal_o, is_jalr_o, count_o
   );

   modport master (
      output enq_valid_i, enq_pc_i, enq_taken_i, enq_target_i,
             enq_is_branch_i, enq_is_jal_i, enq_is_jalr_i, enq_link_i,
             flush_i, bp_ready_i,
      input  enq_ready_o, update_o, update_pc_o, actual_target_o, jal_target_o,
             actual_taken_o, is_branch_o, is_jal_o, is_jalr_o, count_o
   );
endinterface

// File: rtl/bp_update_queue.sv
// Branch-predictor update queue: in-order circular FIFO, 1-cycle latency (0 when BP_UPDQ_BYPASS_EN bypasses an empty queue).
// Backpressure: enq_ready_o drops only when full; the head and all update fields hold while bp_ready_i is low.
module bp_update_queue #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   bp_update_queue_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] target;
      logic [ADDR_WIDTH-1:0] link;
      logic                  taken;
      logic                  is_branch;
      logic                  is_jal;
      logic                  is_jalr;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   entry_t enq_entry;
   entry_t out_entry;
   logic   has_class;
   logic   enq_ready;
   logic   enq_fire;
   logic   head_vld;
   logic   deq;
   logic   bypass;
   logic   store;

   always_comb begin
      enq_entry.pc        = bus.enq_pc_i;
      enq_entry.target    = bus.enq_target_i;
      enq_entry.link      = bus.enq_link_i;
      enq_entry.taken     = bus.enq_taken_i;
      enq_entry.is_branch = bus.enq_is_branch_i;
      enq_entry.is_jal    = bus.enq_is_jal_i;
      enq_entry.is_jalr   = bus.enq_is_jalr_i;

      has_class = bus.enq_is_branch_i | bus.enq_is_jal_i | bus.enq_is_jalr_i;
      enq_ready = (count_q < CNT_W'(DEPTH));
      // Classless handshakes complete on the interface but never touch state.
      enq_fire  = bus.enq_valid_i && enq_ready && !bus.flush_i && has_class;

      head_vld  = (count_q != '0) && !rst_i;
      deq       = head_vld && bus.bp_ready_i && !bus.flush_i;
`ifdef BP_UPDQ_BYPASS_EN
      bypass    = enq_fire && (count_q == '0) && bus.bp_ready_i && !rst_i;
`else
      bypass    = 1'b0;
`endif
      store     = enq_fire && !bypass;

      out_entry = '0;
      if (head_vld) begin
         out_entry = mem_q[rd_ptr_q];
      end else if (bypass) begin
         out_entry = enq_entry;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({store, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk_i) begin
      if (store) begin
         mem_q[wr_ptr_q] <= enq_entry;
      end
   end

   assign bus.enq_ready_o     = enq_ready;
   assign bus.update_o        = deq | bypass;
   assign bus.update_pc_o     = out_entry.pc;
   assign bus.actual_target_o = out_entry.target;
   assign bus.jal_target_o    = out_entry.link;
   assign bus.actual_taken_o  = out_entry.taken;
   assign bus.is_branch_o     = out_entry.is_branch;
   assign bus.is_jal_o        = out_entry.is_jal;
   assign bus.is_jalr_o       = out_entry.is_jalr;
   assign bus.count_o         = count_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed bench for bp_update_queue at DEPTH=4; expectations are hand-computed per step.
module tb_bp_update_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic clk_i;
   logic rst_i;
   int   checks = 0;
   int   errors = 0;

   bp_update_queue_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

   bp_update_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_enq(input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] link,
                          input logic tkn, input logic br, input logic jal, input logic jalr);
      bus.enq_valid_i     = 1'b1;
      bus.enq_pc_i        = pc;
      bus.enq_target_i    = tgt;
      bus.enq_link_i      = link;
      bus.enq_taken_i     = tkn;
      bus.enq_is_branch_i = br;
      bus.enq_is_jal_i    = jal;
      bus.enq_is_jalr_i   = jalr;
   endtask

   task automatic idle_enq();
      bus.enq_valid_i     = 1'b0;
      bus.enq_pc_i        = '0;
      bus.enq_target_i    = '0;
      bus.enq_link_i      = '0;
      bus.enq_taken_i     = 1'b0;
      bus.enq_is_branch_i = 1'b0;
      bus.enq_is_jal_i    = 1'b0;
      bus.enq_is_jalr_i   = 1'b0;
   endtask

   logic [31:0] exp_pc   [4];
   logic [31:0] exp_link [4];
   logic        exp_jal  [4];
   logic        exp_jalr [4];

   initial begin
      exp_pc[0] = 32'h3000; exp_link[0] = 32'h3004; exp_jal[0] = 1'b1; exp_jalr[0] = 1'b0;
      exp_pc[1] = 32'h3100; exp_link[1] = 32'h3104; exp_jal[1] = 1'b1; exp_jalr[1] = 1'b0;
      exp_pc[2] = 32'h31FC; exp_link[2] = 32'h0;    exp_jal[2] = 1'b0; exp_jalr[2] = 1'b1;
      exp_pc[3] = 32'h30FC; exp_link[3] = 32'h0;    exp_jal[3] = 1'b0; exp_jalr[3] = 1'b1;

      rst_i          = 1'b1;
      bus.flush_i    = 1'b0;
      bus.bp_ready_i = 1'b0;
      idle_enq();
      tick();
      tick();
      rst_i = 1'b0;
      #1;
      check("rst_count",     32'(bus.count_o), 32'd0);
      check("rst_enq_ready", 32'(bus.enq_ready_o), 32'd1);
      check("rst_update",    32'(bus.update_o), 32'd0);
      check("rst_pc",        bus.update_pc_o, 32'h0);

      // Single taken branch through the queue.
      bus.bp_ready_i = 1'b1;
      set_enq(32'h1008, 32'h1020, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
`ifdef BP_UPDQ_BYPASS_EN
      check("byp_update", 32'(bus.update_o), 32'd1);
      check("byp_pc",     bus.update_pc_o, 32'h1008);
      check("byp_target", bus.actual_target_o, 32'h1020);
      check("byp_count",  32'(bus.count_o), 32'd0);
      tick();
      idle_enq();
      #1;
      check("byp_count_after",  32'(bus.count_o), 32'd0);
      check("byp_update_after", 32'(bus.update_o), 32'd0);
`else
      check("t1_same_cycle_update", 32'(bus.update_o), 32'd0);
      tick();
      idle_enq();
      #1;
      check("t1_update",    32'(bus.update_o), 32'd1);
      check("t1_pc",        bus.update_pc_o, 32'h1008);
      check("t1_target",    bus.actual_target_o, 32'h1020);
      check("t1_taken",     32'(bus.actual_taken_o), 32'd1);
      check("t1_is_branch", 32'(bus.is_branch_o), 32'd1);
      check("t1_count",     32'(bus.count_o), 32'd1);
      tick();
      #1;
      check("t1_count_after",  32'(bus.count_o), 32'd0);
      check("t1_update_after", 32'(bus.update_o), 32'd0);
      check("t1_pc_empty",     bus.update_pc_o, 32'h0);
`endif

      // Classless handshake is accepted and dropped.
      set_enq(32'h1000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check("t2_enq_ready", 32'(bus.enq_ready_o), 32'd1);
      check("t2_update",    32'(bus.update_o), 32'd0);
      tick();
      idle_enq();
      #1;
      check("t2_count",        32'(bus.count_o), 32'd0);
      check("t2_update_after", 32'(bus.update_o), 32'd0);

      // Fill to DEPTH with the predictor stalled.
      bus.bp_ready_i = 1'b0;
      set_enq(32'h3000, 32'h3100, 32'h3004, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      set_enq(32'h3100, 32'h31F0, 32'h3104, 1'b1, 1'b0, 1'b1, 1'b0); tick();
      set_enq(32'h31FC, 32'h3104, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1); tick();
      set_enq(32'h30FC, 32'h3004, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1); tick();
      idle_enq();
      #1;
      check("t3_count",     32'(bus.count_o), 32'd4);
      check("t3_enq_ready", 32'(bus.enq_ready_o), 32'd0);
      check("t3_update",    32'(bus.update_o), 32'd0);
      check("t3_head_pc",   bus.update_pc_o, 32'h3000);
      set_enq(32'h3200, 32'h3300, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      check("t3_fifth_ready", 32'(bus.enq_ready_o), 32'd0);
      tick();
      idle_enq();
      #1;
      check("t3_fifth_count", 32'(bus.count_o), 32'd4);
      check("t3_head_stable", bus.update_pc_o, 32'h3000);

      // Drain in arrival order.
      bus.bp_ready_i = 1'b1;
      #1;
      check("t4_ready_full_while_deq", 32'(bus.enq_ready_o), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t4_update_%0d", i), 32'(bus.update_o), 32'd1);
         check($sformatf("t4_pc_%0d", i),     bus.update_pc_o, exp_pc[i]);
         check($sformatf("t4_jal_%0d", i),    32'(bus.is_jal_o), 32'(exp_jal[i]));
         check($sformatf("t4_jalr_%0d", i),   32'(bus.is_jalr_o), 32'(exp_jalr[i]));
         check($sformatf("t4_link_%0d", i),   bus.jal_target_o, exp_link[i]);
         tick();
      end
      check("t4_update_done", 32'(bus.update_o), 32'd0);
      check("t4_count_done",  32'(bus.count_o), 32'd0);

      // Flush at count 2 with a colliding enqueue.
      bus.bp_ready_i = 1'b0;
      set_enq(32'h4000, 32'h4100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      set_enq(32'h4004, 32'h4104, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      idle_enq();
      #1;
      check("t5_count_pre", 32'(bus.count_o), 32'd2);
      bus.flush_i = 1'b1;
      set_enq(32'h2000, 32'h2100, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      check("t5_update_flush", 32'(bus.update_o), 32'd0);
      tick();
      bus.flush_i    = 1'b0;
      bus.bp_ready_i = 1'b1;
      idle_enq();
      #1;
      check("t5_count",  32'(bus.count_o), 32'd0);
      check("t5_update", 32'(bus.update_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("t5_never_%0d", k), 32'(bus.update_o), 32'd0);
      end

      // Nine simultaneous enqueue/dequeue pairs at count 1 wrap both pointers.
      bus.bp_ready_i = 1'b0;
      set_enq(32'h5000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.bp_ready_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         set_enq(32'h5004 + 32'(4 * i), 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
         #1;
         check($sformatf("t6_update_%0d", i), 32'(bus.update_o), 32'd1);
         check($sformatf("t6_pc_%0d", i),     bus.update_pc_o, 32'h5000 + 32'(4 * i));
         check($sformatf("t6_count_%0d", i),  32'(bus.count_o), 32'd1);
         tick();
      end
      idle_enq();
      #1;
      check("t6_last_pc",     bus.update_pc_o, 32'h5024);
      check("t6_last_update", 32'(bus.update_o), 32'd1);
      tick();
      check("t6_count_end", 32'(bus.count_o), 32'd0);

      // Reset mid-operation discards everything.
      bus.bp_ready_i = 1'b0;
      set_enq(32'h6000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      set_enq(32'h6004, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      set_enq(32'h6008, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      idle_enq();
      #1;
      check("t7_count_pre", 32'(bus.count_o), 32'd3);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      check("t7_count",     32'(bus.count_o), 32'd0);
      check("t7_update",    32'(bus.update_o), 32'd0);
      check("t7_enq_ready", 32'(bus.enq_ready_o), 32'd1);
      check("t7_pc",        bus.update_pc_o, 32'h0);
      bus.bp_ready_i = 1'b1;
      tick();
      check("t7_no_drain", 32'(bus.update_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
